// File: rtl/ft6_pkg.sv
// Shared types and constants for the FT601/FT600 245-synchronous-FIFO write engine.
package ft6_pkg;

    // Write engine states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TXE_WAIT = 2'd1,
        WR_DATA  = 2'd2,
        GAP      = 2'd3
    } ft6_state_t;

    // Default number of wr_n-high cycles inserted after every burst
    localparam int FT6_GAP_DEFAULT = 2;

    // The only bus widths the FT600 (16) and FT601 (32) support
    localparam int FT6_WIDTH_NARROW = 16;
    localparam int FT6_WIDTH_WIDE   = 32;

    function automatic bit ft6_width_ok(input int width);
        return (width == FT6_WIDTH_NARROW) || (width == FT6_WIDTH_WIDE);
    endfunction

endpackage

// File: rtl/ft6_stream_writer_if.sv
// Upstream valid/ready word stream feeding the FT6 write engine.
// master = sample packer side, slave = ft6_stream_writer side.
interface ft6_stream_writer_if #(
    parameter int DATA_W = 32,
    parameter int BE_W   = DATA_W / 8
);
    logic [DATA_W-1:0] s_data;
    logic [BE_W-1:0]   s_be;
    logic              s_last;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, s_be, s_last, s_valid, input s_ready);
    modport slave  (input s_data, s_be, s_last, s_valid, output s_ready);
endinterface

// File: rtl/ft6_out_slot.sv
// Single-word output register for the FT6 pads. A word stays here until the
// FT6 FIFO accepts it, so a word refused by TXE is replayed, never lost.
module ft6_out_slot #(
    parameter int DATA_W = 32,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] load_data,
    input  logic [BE_W-1:0]   load_be,
    input  logic              load_last,
    output logic [DATA_W-1:0] data,
    output logic [BE_W-1:0]   be,
    output logic              last,
    output logic              valid
);

    // Load wins over clear; with neither the held word is kept for replay
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            be    <= '1;
            last  <= 1'b0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            be    <= load_be;
            last  <= load_last;
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ft6_stream_writer.sv
// FT601/FT600 245-synchronous-FIFO write engine: drains an upstream word
// stream onto the FT6 bus in bursts with lossless TXE back-pressure.
// Optional build macro FT6_TEST_PATTERN_EN adds a test_mode input that
// replaces the upstream stream with an incrementing byte pattern.
module ft6_stream_writer
    import ft6_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int BE_W      = DATA_W / 8,
    parameter int BURST_MAX = 1024,
    parameter int GAP_CYC   = FT6_GAP_DEFAULT
) (
    input  logic                  ft6_clk,
    input  logic                  ft6_rst_n,
    input  logic                  enable,
    ft6_stream_writer_if.slave    s,
`ifdef FT6_TEST_PATTERN_EN
    input  logic                  test_mode,
`endif
    input  logic                  ft6_txe_n,
    output logic                  ft6_wr_n,
    output logic [DATA_W-1:0]     ft6_data,
    output logic [BE_W-1:0]       ft6_be,
    output logic                  ft6_data_oe,
    output logic                  busy,
    output logic [31:0]           words_sent,
    output logic [15:0]           stall_count
);

    localparam int BC_W = $clog2(BURST_MAX + 1);

    if (!ft6_width_ok(DATA_W)) begin : g_bad_width
        $error("ft6_stream_writer: DATA_W must be 16 or 32");
    end

    ft6_state_t        state;
    ft6_state_t        state_next;
    logic [BC_W-1:0]   burst_cnt;
    logic [15:0]       gap_cnt;

    logic              acc;
    logic              at_limit;
    logic              end_pending;
    logic              room;
    logic              load;
    logic              clear;
    logic              slot_valid_next;
    logic [DATA_W-1:0] load_data;
    logic [BE_W-1:0]   load_be;
    logic              load_last;

    logic [DATA_W-1:0] slot_data;
    logic [BE_W-1:0]   slot_be;
    logic              slot_last;
    logic              slot_valid;

`ifdef FT6_TEST_PATTERN_EN
    logic [7:0]        pat_cnt;
`endif

    ft6_out_slot #(
        .DATA_W (DATA_W),
        .BE_W   (BE_W)
    ) u_slot (
        .clk       (ft6_clk),
        .rst_n     (ft6_rst_n),
        .load      (load),
        .clear     (clear),
        .load_data (load_data),
        .load_be   (load_be),
        .load_last (load_last),
        .data      (slot_data),
        .be        (slot_be),
        .last      (slot_last),
        .valid     (slot_valid)
    );

    assign ft6_data = slot_data;
    assign ft6_be   = slot_valid ? slot_be : {BE_W{1'b1}};

    // Handshake, slot control and next state; a word that would end the burst blocks preloading
    always_comb begin
        acc         = ~ft6_wr_n & ~ft6_txe_n;
        at_limit    = (burst_cnt == BC_W'(BURST_MAX - 1));
        end_pending = slot_valid & (slot_last | at_limit);
        room        = (state == WR_DATA) & ~ft6_txe_n & enable
                    & (~slot_valid | acc) & ~end_pending;
`ifdef FT6_TEST_PATTERN_EN
        s.s_ready   = room & ~test_mode;
        load        = room & (test_mode | s.s_valid);
        load_data   = test_mode ? {BE_W{pat_cnt}} : s.s_data;
        load_be     = test_mode ? {BE_W{1'b1}} : s.s_be;
        load_last   = ~test_mode & s.s_last;
`else
        s.s_ready   = room;
        load        = room & s.s_valid;
        load_data   = s.s_data;
        load_be     = s.s_be;
        load_last   = s.s_last;
`endif
        clear           = acc & ~load;
        slot_valid_next = load | (slot_valid & ~acc);

        state_next = state;
        case (state)
            IDLE:     if (enable && !ft6_txe_n) state_next = TXE_WAIT;
            TXE_WAIT: state_next = WR_DATA;
            WR_DATA:  if (ft6_txe_n || (acc && (slot_last || at_limit)) ||
                          (!enable && !slot_valid)) state_next = GAP;
            GAP:      if (gap_cnt == 16'(GAP_CYC - 1)) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // FSM with registered bus strobe, pad drive enable and busy flag
    always_ff @(posedge ft6_clk or negedge ft6_rst_n) begin
        if (!ft6_rst_n) begin
            state       <= IDLE;
            ft6_wr_n    <= 1'b1;
            ft6_data_oe <= 1'b0;
            busy        <= 1'b0;
            burst_cnt   <= '0;
            gap_cnt     <= '0;
        end else begin
            state       <= state_next;
            ft6_wr_n    <= ~((state_next == WR_DATA) & slot_valid_next);
            ft6_data_oe <= (state_next != IDLE);
            busy        <= (state_next != IDLE);
            if (state_next == TXE_WAIT) begin
                burst_cnt <= '0;
            end else if (acc) begin
                burst_cnt <= burst_cnt + BC_W'(1);
            end
            gap_cnt     <= (state == GAP) ? gap_cnt + 16'd1 : 16'd0;
        end
    end

    // Status counters: accepted words (wrapping) and TXE-ended bursts (saturating)
    always_ff @(posedge ft6_clk or negedge ft6_rst_n) begin
        if (!ft6_rst_n) begin
            words_sent  <= '0;
            stall_count <= '0;
        end else begin
            if (acc) begin
                words_sent <= words_sent + 32'd1;
            end
            if ((state == WR_DATA) && ft6_txe_n && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

`ifdef FT6_TEST_PATTERN_EN
    // Pattern byte advances each time a pattern word enters the slot
    always_ff @(posedge ft6_clk or negedge ft6_rst_n) begin
        if (!ft6_rst_n) begin
            pat_cnt <= '0;
        end else if (load && test_mode) begin
            pat_cnt <= pat_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ft6_stream_writer.sv
// Directed bench for ft6_stream_writer (32-bit bus, 4-word bursts, 2-cycle gap).
// Words are queued to a source and to a scoreboard together; a bus monitor pops
// the scoreboard on every FT6 accept and also records burst lengths and gaps.
module tb_ft6_stream_writer;

    localparam int DATA_W    = 32;
    localparam int BE_W      = 4;
    localparam int BURST_MAX = 4;
    localparam int GAP_CYC   = 2;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  be;
        logic        last;
    } word_t;

    logic              ft6_clk   = 1'b0;
    logic              ft6_rst_n = 1'b0;
    logic              enable    = 1'b0;
    logic              ft6_txe_n = 1'b0;
    logic              ft6_wr_n;
    logic [DATA_W-1:0] ft6_data;
    logic [BE_W-1:0]   ft6_be;
    logic              ft6_data_oe;
    logic              busy;
    logic [31:0]       words_sent;
    logic [15:0]       stall_count;
`ifdef FT6_TEST_PATTERN_EN
    logic              test_mode = 1'b0;
`endif

    ft6_stream_writer_if #(.DATA_W(DATA_W)) bus ();

    ft6_stream_writer #(
        .DATA_W    (DATA_W),
        .BURST_MAX (BURST_MAX),
        .GAP_CYC   (GAP_CYC)
    ) dut (
        .ft6_clk     (ft6_clk),
        .ft6_rst_n   (ft6_rst_n),
        .enable      (enable),
        .s           (bus),
`ifdef FT6_TEST_PATTERN_EN
        .test_mode   (test_mode),
`endif
        .ft6_txe_n   (ft6_txe_n),
        .ft6_wr_n    (ft6_wr_n),
        .ft6_data    (ft6_data),
        .ft6_be      (ft6_be),
        .ft6_data_oe (ft6_data_oe),
        .busy        (busy),
        .words_sent  (words_sent),
        .stall_count (stall_count)
    );

    always #5 ft6_clk = ~ft6_clk;

    int         n_checks = 0;
    int         n_errors = 0;
    word_t      src_q[$];
    word_t      exp_q[$];
    int         burst_q[$];
    int         gap_q[$];
    int         run_len  = 0;
    int         high_cnt = 0;
    bit         have_prev = 1'b0;
    bit         pattern_mode = 1'b0;
    logic [7:0] pat_exp = 8'd0;
    int         pat_seen = 0;
    logic       drv_hs;
    word_t      mon_w;
    int         exp_bursts[3] = '{4, 4, 2};
    bit         found;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] data, input logic [3:0] be,
                                 input logic last);
        word_t w;
        w.data = data;
        w.be   = be;
        w.last = last;
        src_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic cycle();
        @(posedge ft6_clk);
        #1;
    endtask

    task automatic startTest();
        burst_q.delete();
        gap_q.delete();
        have_prev = 1'b0;
        high_cnt  = 0;
        enable    = 1'b1;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_wr_n"},   ft6_wr_n, 1);
        checkOutput({tag, "_data"},   ft6_data, 0);
        checkOutput({tag, "_be"},     ft6_be, 4'hF);
        checkOutput({tag, "_oe"},     ft6_data_oe, 0);
        checkOutput({tag, "_ready"},  bus.s_ready, 0);
        checkOutput({tag, "_busy"},   busy, 0);
        checkOutput({tag, "_words"},  words_sent, 0);
        checkOutput({tag, "_stalls"}, stall_count, 0);
    endtask

    // Wait for the scoreboard to drain, then drop enable and wait for IDLE
    task automatic waitDone(input string tag);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 2000) begin
            cycle();
            cyc++;
        end
        checkOutput({tag, "_drained"}, exp_q.size(), 0);
        enable = 1'b0;
        cyc = 0;
        while (busy !== 1'b0 && cyc < 100) begin
            cycle();
            cyc++;
        end
        checkOutput({tag, "_idle"}, busy, 0);
        cycle();
    endtask

    task automatic findOnBus(input logic [31:0] data, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            cycle();
            if (ft6_wr_n === 1'b0 && ft6_data === data) hit = 1'b1;
        end
    endtask

    task automatic checkBursts(input string tag, input int n);
        checkOutput({tag, "_nbursts"}, burst_q.size(), n);
        for (int i = 0; i < burst_q.size() && i < n; i++)
            checkOutput({tag, "_burst_len"}, burst_q[i], exp_bursts[i]);
        for (int i = 0; i < gap_q.size(); i++)
            checkOutput({tag, "_gap_min"}, gap_q[i] >= GAP_CYC + 1, 1);
    endtask

    // Upstream source: present queue head, retire it after a handshake edge
    initial begin
        bus.s_data  = '0;
        bus.s_be    = '1;
        bus.s_last  = 1'b0;
        bus.s_valid = 1'b0;
        forever begin
            @(negedge ft6_clk);
            drv_hs = bus.s_valid & bus.s_ready;
            @(posedge ft6_clk);
            #1;
            if (drv_hs && src_q.size() > 0) void'(src_q.pop_front());
            if (src_q.size() > 0) begin
                bus.s_data  = src_q[0].data;
                bus.s_be    = src_q[0].be;
                bus.s_last  = src_q[0].last;
                bus.s_valid = 1'b1;
            end else begin
                bus.s_valid = 1'b0;
                bus.s_last  = 1'b0;
            end
        end
    end

    // Bus monitor: every accepted FT6 word is checked against the scoreboard
    initial begin
        forever begin
            @(negedge ft6_clk);
            if (ft6_wr_n === 1'b0 && ft6_txe_n === 1'b0) begin
                run_len++;
                if (run_len == 1 && have_prev) gap_q.push_back(high_cnt);
                checkOutput("acc_oe", ft6_data_oe, 1);
                if (pattern_mode) begin
                    checkOutput("pattern_data", ft6_data, {4{pat_exp}});
                    checkOutput("pattern_be", ft6_be, 4'hF);
                    pat_exp = pat_exp + 8'd1;
                    pat_seen++;
                end else if (exp_q.size() == 0) begin
                    checkOutput("unexpected_write_wr_n", ft6_wr_n, 1);
                end else begin
                    mon_w = exp_q.pop_front();
                    checkOutput("acc_data", ft6_data, mon_w.data);
                    checkOutput("acc_be", ft6_be, mon_w.be);
                end
            end else begin
                if (run_len > 0) begin
                    burst_q.push_back(run_len);
                    run_len   = 0;
                    have_prev = 1'b1;
                    high_cnt  = 0;
                end
                if (ft6_wr_n === 1'b1) high_cnt++;
            end
        end
    end

    initial begin
        $display("[TB] start");
        repeat (3) cycle();
        checkReset("rst0");
        ft6_rst_n = 1'b1;
        cycle();

        // Eight-word packet, last on word 8: two full bursts
        startTest();
        for (int i = 1; i <= 8; i++) applyStimulus(32'(i), 4'hF, i == 8);
        waitDone("pkt8");
        checkOutput("pkt8_words_sent", words_sent, 8);
        checkBursts("pkt8", 2);

        // Ten-word packet: bursts of 4, 4, 2
        startTest();
        for (int i = 1; i <= 10; i++) applyStimulus(32'h10 + 32'(i), 4'hF, i == 10);
        waitDone("pkt10");
        checkOutput("pkt10_words_sent", words_sent, 18);
        checkBursts("pkt10", 3);

        // TXE goes high while word 5 is on the bus: it must be held and replayed
        startTest();
        for (int i = 1; i <= 10; i++) applyStimulus(32'h100 + 32'(i), 4'hF, i == 10);
        findOnBus(32'h105, found);
        checkOutput("stall_found_w5", found, 1);
        ft6_txe_n = 1'b1;
        cycle();
        checkOutput("stall_wr_n_high", ft6_wr_n, 1);
        checkOutput("stall_held_data", ft6_data, 32'h105);
        checkOutput("stall_busy", busy, 1);
        repeat (3) cycle();
        ft6_txe_n = 1'b0;
        waitDone("stall");
        checkOutput("stall_words_sent", words_sent, 28);
        checkOutput("stall_count", stall_count, 1);

        // Partial byte enables on the last word only
        startTest();
        applyStimulus(32'h11223344, 4'hF, 1'b0);
        applyStimulus(32'hAABBCCDD, 4'b0011, 1'b1);
        waitDone("be");
        checkOutput("be_words_sent", words_sent, 30);
        checkOutput("be_idle_all_ones", ft6_be, 4'hF);

        // Reset while a word is in flight: it must never reach the bus
        startTest();
        applyStimulus(32'h201, 4'hF, 1'b0);
        applyStimulus(32'h202, 4'hF, 1'b0);
        applyStimulus(32'h203, 4'hF, 1'b1);
        findOnBus(32'h202, found);
        checkOutput("rst_found_w2", found, 1);
        ft6_rst_n = 1'b0;
        #1;
        checkReset("rst_mid");
        src_q.delete();
        exp_q.delete();
        repeat (2) cycle();
        ft6_rst_n = 1'b1;
        repeat (12) cycle();
        checkOutput("rst_no_replay_words", words_sent, 0);
        checkOutput("rst_no_replay_wr_n", ft6_wr_n, 1);
        waitDone("rst");

        // Engine still works after reset
        startTest();
        applyStimulus(32'h300, 4'hF, 1'b1);
        waitDone("post_rst");
        checkOutput("post_rst_words_sent", words_sent, 1);

`ifdef FT6_TEST_PATTERN_EN
        // Test pattern: replicated byte counter, wrapping past 0xFF
        test_mode    = 1'b1;
        pattern_mode = 1'b1;
        pat_exp      = 8'd0;
        enable       = 1'b1;
        for (int i = 0; i < 5000 && pat_seen < 260; i++) begin
            cycle();
            if (i == 20) checkOutput("pattern_s_ready", bus.s_ready, 0);
        end
        checkOutput("pattern_wrapped", pat_seen >= 260, 1);
        enable = 1'b0;
        for (int i = 0; i < 100 && busy !== 1'b0; i++) cycle();
        checkOutput("pattern_idle", busy, 0);
        pattern_mode = 1'b0;
        test_mode    = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
